// File: rtl/sonic_eth_st_timing_adapter_fifo.sv
// rtl/sonic_eth_st_timing_adapter_fifo.sv - ready-latency-N to ready-latency-0 Avalon-ST adapter
// Credit-based circular buffer absorbs in-flight beats; unpermitted beats are dropped and counted.
module sonic_eth_st_timing_adapter_fifo #(
   parameter int DATA_W           = 72,
   parameter int IN_READY_LATENCY = 0,
   parameter int DEPTH            = 4,
   parameter int CNT_W            = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   output logic                     in_ready,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_count,
   input  logic                     clear_stats
);
   localparam int AW  = $clog2(DEPTH);
   localparam int LAT = IN_READY_LATENCY;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW+1:0]     pending;
   logic              permit;
   logic              wr_en;
   logic              rd_en;
   logic              drop;

   // Grants issued but whose beats have not arrived yet still reserve a slot.
   assign in_ready = reset_n &&
                     (((AW+2)'(occupancy) + pending) < (AW+2)'(DEPTH));

   generate
      if (LAT == 0) begin : g_no_hist
         assign pending = '0;
         assign permit  = in_ready;
      end else begin : g_hist
         logic [LAT-1:0] g;
         logic [LAT:0]   g_next;

         assign g_next = {g, in_ready};
         assign permit = g[LAT-1];

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               g <= '0;
            end else begin
               g <= g_next[LAT-1:0];
            end
         end

         always_comb begin
            pending = '0;
            for (int i = 0; i < LAT; i++) begin
               pending = pending + (AW+2)'(g[i]);
            end
         end
      end
   endgenerate

   assign out_valid = (occupancy != '0);
   assign out_data  = mem[rd_ptr];
   assign wr_en     = in_valid && permit;
   assign drop      = in_valid && !permit;
   assign rd_en     = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   occupancy <= occupancy + (AW+1)'(1);
            2'b01:   occupancy <= occupancy - (AW+1)'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Clear takes priority over a drop landing in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear_stats) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != '1) begin
            drop_count <= drop_count + CNT_W'(1);
         end
      end
   end

   a_no_write_when_full : assert property (@(posedge clk) disable iff (!reset_n)
      !(wr_en && (occupancy == (AW+1)'(DEPTH))));

endmodule
